// File: rtl/regfile_pkg.sv
// Shared constants and reset-value helper for the multi-port register file.
package regfile_pkg;

   localparam int unsigned REG_ZERO = 0;
   localparam int unsigned REG_SP   = 2;
   localparam int unsigned REG_GP   = 3;

   localparam logic [31:0] SP_INIT_DEF = 32'h0000_2ffc;
   localparam logic [31:0] GP_INIT_DEF = 32'h0000_1800;

   // Architectural reset value of register idx; wide return so callers can truncate to DW.
   function automatic logic [63:0] regfile_init(
      input int unsigned idx,
      input logic [63:0] sp_init = 64'(SP_INIT_DEF),
      input logic [63:0] gp_init = 64'(GP_INIT_DEF)
   );
      logic [63:0] val;
      val = '0;
      if (idx == REG_SP) val = sp_init;
      else if (idx == REG_GP) val = gp_init;
      return val;
   endfunction

endpackage

// File: rtl/reg_file_mp_scoreboard.sv
// Per-register busy scoreboard: issue sets, writeback clears, issue wins on a tie.
module rf_scoreboard #(
   parameter int unsigned AW = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  iss_valid,
   input  logic [AW-1:0]         iss_rd,
   input  logic                  we0,
   input  logic [AW-1:0]         wa0,
   input  logic                  we1,
   input  logic [AW-1:0]         wa1,
   output logic [(1<<AW)-1:0]    busy,
   output logic [AW:0]           busy_cnt
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DEPTH-1:0] busy_nxt;
   logic [AW:0]      cnt_nxt;

   // Next busy vector and its popcount; reg 0 is never tracked.
   always_comb begin
      busy_nxt = busy;
      cnt_nxt  = '0;
      busy_nxt[0] = 1'b0;
      for (int r = 1; r < DEPTH; r++) begin
         if (iss_valid && iss_rd == AW'(r))
            busy_nxt[r] = 1'b1;
         else if ((we0 && wa0 == AW'(r)) || (we1 && wa1 == AW'(r)))
            busy_nxt[r] = 1'b0;
         cnt_nxt = cnt_nxt + (AW+1)'(busy_nxt[r]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file with two write ports and a busy scoreboard.
// Optional write-first forwarding when REGFILE_BYPASS_EN is defined.
module reg_file_mp
   import regfile_pkg::*;
#(
   parameter int unsigned    DW      = 32,
   parameter int unsigned    AW      = 5,
   parameter int unsigned    NR      = 3,
   parameter logic [DW-1:0]  SP_INIT = DW'(SP_INIT_DEF),
   parameter logic [DW-1:0]  GP_INIT = DW'(GP_INIT_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NR*AW-1:0]  ra,
   output logic [NR*DW-1:0]  rd,
   output logic [NR-1:0]     rd_busy,
   input  logic [AW-1:0]     wa0,
   input  logic [DW-1:0]     wd0,
   input  logic              we0,
   input  logic [AW-1:0]     wa1,
   input  logic [DW-1:0]     wd1,
   input  logic              we1,
   input  logic              iss_valid,
   input  logic [AW-1:0]     iss_rd,
   output logic [AW:0]       busy_cnt
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [DW-1:0]    rf_q [DEPTH];
   logic [DEPTH-1:0] busy;

   // One storage word per register; reg 0 is hardwired to zero.
   for (genvar r = 0; r < DEPTH; r++) begin : g_reg
      logic [DW-1:0] q;
      if (r == 0) begin : g_zero
         assign q = '0;
      end else begin : g_live
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               q <= DW'(regfile_init(r, 64'(SP_INIT), 64'(GP_INIT)));
            else if (we1 && wa1 == AW'(r))
               q <= wd1;
            else if (we0 && wa0 == AW'(r))
               q <= wd0;
         end
      end
      assign rf_q[r] = q;
   end

   rf_scoreboard #(.AW(AW)) u_sb (
      .clk       (clk),
      .rst       (rst),
      .iss_valid (iss_valid),
      .iss_rd    (iss_rd),
      .we0       (we0),
      .wa0       (wa0),
      .we1       (we1),
      .wa1       (wa1),
      .busy      (busy),
      .busy_cnt  (busy_cnt)
   );

   // Read muxes; busy[0] and rf_q[0] are constant zero.
   always_comb begin
      rd      = '0;
      rd_busy = '0;
      for (int i = 0; i < NR; i++) begin
         rd[i*DW +: DW] = rf_q[ra[i*AW +: AW]];
         rd_busy[i]     = busy[ra[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
         if (ra[i*AW +: AW] != '0) begin
            if (we0 && wa0 == ra[i*AW +: AW]) rd[i*DW +: DW] = wd0;
            if (we1 && wa1 == ra[i*AW +: AW]) rd[i*DW +: DW] = wd1;
            if (((we0 && wa0 == ra[i*AW +: AW]) || (we1 && wa1 == ra[i*AW +: AW])) &&
                !(iss_valid && iss_rd == ra[i*AW +: AW]))
               rd_busy[i] = 1'b0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and model-checked bench for reg_file_mp.
module tb_reg_file_mp;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [NR*AW-1:0]  ra = '0;
   logic [NR*DW-1:0]  rd;
   logic [NR-1:0]     rd_busy;
   logic [AW-1:0]     wa0 = '0, wa1 = '0, iss_rd = '0;
   logic [DW-1:0]     wd0 = '0, wd1 = '0;
   logic              we0 = 1'b0, we1 = 1'b0, iss_valid = 1'b0;
   logic [AW:0]       busy_cnt;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_rf [32];
   logic [31:0] m_busy;

   reg_file_mp dut (
      .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rd_busy(rd_busy),
      .wa0(wa0), .wd0(wd0), .we0(we0), .wa1(wa1), .wd1(wd1), .we1(we1),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   task automatic idle();
      we0 = 0; we1 = 0; iss_valid = 0;
      wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] init_val(input int a);
      if (a == 2) return 32'h0000_2ffc;
      if (a == 3) return 32'h0000_1800;
      return 32'h0;
   endfunction

   task automatic test_reset();
      step();
      we0 = 1; wa0 = 5'd9; wd0 = 32'h1234; iss_valid = 1; iss_rd = 5'd9;
      step();
      idle();
      #2 rst = 1;
      #1;
      for (int a = 0; a < 32; a++) begin
         ra = {AW'(a), AW'(a), AW'(a)};
         #1;
         for (int p = 0; p < NR; p++) begin
            checks++;
            if (rd[p*DW +: DW] !== init_val(a)) begin
               errors++;
               $display("FAIL reset_rd a=%0d p=%0d got %h exp %h", a, p, rd[p*DW +: DW], init_val(a));
            end
            checks++;
            if (rd_busy[p] !== 1'b0) begin
               errors++;
               $display("FAIL reset_busy a=%0d p=%0d got %b exp 0", a, p, rd_busy[p]);
            end
         end
      end
      checks++;
      if (busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reset_cnt got %0d exp 0", busy_cnt);
      end
      @(negedge clk) rst = 0;
      step();
   endtask

   task automatic test_reg0();
      ra = '0;
      we0 = 1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
      step();
      idle();
      iss_valid = 1; iss_rd = 5'd0;
      step();
      idle();
      #1;
      for (int p = 0; p < NR; p++) begin
         checks++;
         if (rd[p*DW +: DW] !== 32'h0 || rd_busy[p] !== 1'b0) begin
            errors++;
            $display("FAIL reg0 p=%0d got %h/%b exp 0/0", p, rd[p*DW +: DW], rd_busy[p]);
         end
      end
      checks++;
      if (busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL reg0_cnt got %0d exp 0", busy_cnt);
      end
   endtask

   task automatic test_dual_write();
      logic [31:0] exp_now;
      ra = {5'd5, 5'd5, 5'd5};
      we0 = 1; wa0 = 5'd5; wd0 = 32'h11;
      we1 = 1; wa1 = 5'd5; wd1 = 32'h22;
      #1;
      exp_now = BYP ? 32'h22 : 32'h0;
      checks++;
      if (rd[DW-1:0] !== exp_now) begin
         errors++;
         $display("FAIL dual_same_cycle got %h exp %h", rd[DW-1:0], exp_now);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd[DW-1:0] !== 32'h22) begin
         errors++;
         $display("FAIL dual_next got %h exp 00000022", rd[DW-1:0]);
      end
   endtask

   task automatic test_scoreboard();
      ra = {5'd7, 5'd7, 5'd7};
      iss_valid = 1; iss_rd = 5'd7;
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1) begin
         errors++;
         $display("FAIL sb_issue got busy=%b cnt=%0d exp 1/1", rd_busy[0], busy_cnt);
      end
      iss_valid = 1; iss_rd = 5'd7; we0 = 1; wa0 = 5'd7; wd0 = 32'h77;
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL sb_tie_comb got %b exp 1", rd_busy[0]);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b1 || busy_cnt !== 6'd1 || rd[DW-1:0] !== 32'h77) begin
         errors++;
         $display("FAIL sb_tie got busy=%b cnt=%0d rd=%h exp 1/1/00000077", rd_busy[0], busy_cnt, rd[DW-1:0]);
      end
      we1 = 1; wa1 = 5'd7; wd1 = 32'h88;
      #1;
      checks++;
      if (rd_busy[0] !== !BYP || rd[DW-1:0] !== (BYP ? 32'h88 : 32'h77)) begin
         errors++;
         $display("FAIL sb_wb_comb got busy=%b rd=%h exp %b", rd_busy[0], rd[DW-1:0], !BYP);
      end
      step();
      idle();
      #1;
      checks++;
      if (rd_busy[0] !== 1'b0 || busy_cnt !== 6'd0 || rd[DW-1:0] !== 32'h88) begin
         errors++;
         $display("FAIL sb_wb got busy=%b cnt=%0d rd=%h exp 0/0/00000088", rd_busy[0], busy_cnt, rd[DW-1:0]);
      end
   endtask

   task automatic test_fill();
      for (int r = 1; r < 32; r++) begin
         iss_valid = 1; iss_rd = AW'(r);
         step();
      end
      idle();
      #1;
      checks++;
      if (busy_cnt !== 6'd31) begin
         errors++;
         $display("FAIL fill_cnt got %0d exp 31", busy_cnt);
      end
      for (int k = 0; k < 16; k++) begin
         we0 = 1; wa0 = AW'(2*k+1); wd0 = 32'hA500_0000 | 32'(2*k+1);
         we1 = (2*k+2 <= 31); wa1 = AW'(2*k+2); wd1 = 32'hA500_0000 | 32'(2*k+2);
         step();
         if (k == 7) begin
            checks++;
            if (busy_cnt !== 6'd15) begin
               errors++;
               $display("FAIL drain_mid got %0d exp 15", busy_cnt);
            end
         end
      end
      idle();
      #1;
      checks++;
      if (busy_cnt !== 6'd0) begin
         errors++;
         $display("FAIL drain_end got %0d exp 0", busy_cnt);
      end
      for (int r = 1; r < 32; r++) begin
         ra = {5'd0, AW'(r), 5'd0};
         #1;
         checks++;
         if (rd[DW +: DW] !== (32'hA500_0000 | 32'(r)) || rd_busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL fill_data r=%0d got %h/%b exp %h/0", r, rd[DW +: DW], rd_busy[1], 32'hA500_0000 | 32'(r));
         end
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 32; r++) m_rf[r] = init_val(r);
      m_busy = '0;
   endtask

   task automatic test_random();
      logic [31:0] e_rd;
      logic        e_bz;
      logic [4:0]  a;
      for (int n = 0; n < 400; n++) begin
         ra = {5'($urandom_range(0, 31)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         if (n == 0 || $urandom_range(0, 39) == 0) begin
            idle();
            rst = 1;
            model_reset();
         end else begin
            rst = 0;
            we0 = 1'($urandom); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
            we1 = 1'($urandom); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
            iss_valid = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
         end
         #1;
         for (int p = 0; p < NR; p++) begin
            a = ra[p*AW +: AW];
            e_rd = m_rf[a];
            e_bz = (a != 0) && m_busy[a];
            if (BYP && a != 0) begin
               if (we0 && wa0 == a) e_rd = wd0;
               if (we1 && wa1 == a) e_rd = wd1;
               if (((we0 && wa0 == a) || (we1 && wa1 == a)) && !(iss_valid && iss_rd == a)) e_bz = 0;
            end
            checks++;
            if (rd[p*DW +: DW] !== e_rd || rd_busy[p] !== e_bz) begin
               errors++;
               $display("FAIL rand_rd n=%0d p=%0d a=%0d got %h/%b exp %h/%b", n, p, a, rd[p*DW +: DW], rd_busy[p], e_rd, e_bz);
            end
         end
         checks++;
         if (busy_cnt !== 6'($countones(m_busy))) begin
            errors++;
            $display("FAIL rand_cnt n=%0d got %0d exp %0d", n, busy_cnt, $countones(m_busy));
         end
         @(posedge clk);
         if (!rst) begin
            for (int r = 1; r < 32; r++) begin
               if (iss_valid && iss_rd == 5'(r)) m_busy[r] = 1'b1;
               else if ((we0 && wa0 == 5'(r)) || (we1 && wa1 == 5'(r))) m_busy[r] = 1'b0;
            end
            if (we0 && wa0 != 0) m_rf[wa0] = wd0;
            if (we1 && wa1 != 0) m_rf[wa1] = wd1;
         end
         #1;
      end
      rst = 0;
      idle();
      step();
   endtask

   initial begin
      idle();
      rst = 1;
      #12 rst = 0;
      test_reset();
      test_reg0();
      test_dual_write();
      test_scoreboard();
      test_fill();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
